// File: rtl/shift_chain_if.sv
// Command/data bundle for the shift chain: the producer side drives strobes
// and command fields, the chain drives the handshake response and data.
interface shift_chain_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [1:0]       cmd_mode;
  logic             cmd_fill;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  // Producer / test side
  modport master (
    output clr, load, load_data, cmd_valid, cmd_dir, cmd_mode, cmd_fill, cmd_count,
    input  cmd_ready, data_out, busy, done
  );

  // Shift chain side
  modport slave (
    input  clr, load, load_data, cmd_valid, cmd_dir, cmd_mode, cmd_fill, cmd_count,
    output cmd_ready, data_out, busy, done
  );
endinterface

// File: rtl/shift_chain_seq.sv
// Registered WIDTH-bit shift/rotate chain. A command moves the chain one bit
// position per clock for cmd_count steps, then pulses done for one cycle.
// Priority per edge: clr > load > command accept > shift step.
module shift_chain_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst_n,
  shift_chain_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] chain_reg, chain_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             dir_reg, dir_next;
  logic [1:0]       mode_reg, mode_next;
  logic             fill_reg, fill_next;
  logic             done_reg, done_next;

  logic             step_bit;
  logic [WIDTH-1:0] stepped;

  // Bit entering the vacated end for one step of the latched command
  always_comb begin
    step_bit = 1'b0;
    case (mode_reg)
      2'b00: step_bit = 1'b0;
      2'b01: step_bit = fill_reg;
      2'b10: step_bit = dir_reg ? chain_reg[0] : chain_reg[WIDTH-1];
      2'b11: step_bit = dir_reg ? chain_reg[WIDTH-1] : 1'b0;
      default: step_bit = 1'b0;
    endcase
  end

  // One-position move of the chain in the latched direction
  always_comb begin
    if (dir_reg) stepped = {step_bit, chain_reg[WIDTH-1:1]};
    else         stepped = {chain_reg[WIDTH-2:0], step_bit};
  end

  // Next-state logic: clear, load, command accept and stepping
  always_comb begin
    state_next     = state_reg;
    chain_next     = chain_reg;
    remaining_next = remaining_reg;
    dir_next       = dir_reg;
    mode_next      = mode_reg;
    fill_next      = fill_reg;
    done_next      = 1'b0;
    if (bus.clr) begin
      chain_next     = '0;
      state_next     = IDLE;
      remaining_next = '0;
    end else if (state_reg == IDLE) begin
      if (bus.load) begin
        chain_next = bus.load_data;
      end else if (bus.cmd_valid) begin
        dir_next  = bus.cmd_dir;
        mode_next = bus.cmd_mode;
        fill_next = bus.cmd_fill;
        if (bus.cmd_count == '0) begin
          // Zero-step command completes immediately with the chain untouched
          done_next = 1'b1;
        end else begin
          state_next     = SHIFT;
          remaining_next = bus.cmd_count;
        end
      end
    end else begin
      chain_next     = stepped;
      remaining_next = remaining_reg - CNT_W'(1);
      if (remaining_reg == CNT_W'(1)) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  // State and datapath registers; rst_n is the only asynchronous path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      chain_reg     <= '0;
      remaining_reg <= '0;
      dir_reg       <= 1'b0;
      mode_reg      <= 2'b00;
      fill_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      chain_reg     <= chain_next;
      remaining_reg <= remaining_next;
      dir_reg       <= dir_next;
      mode_reg      <= mode_next;
      fill_reg      <= fill_next;
      done_reg      <= done_next;
    end
  end

  assign bus.cmd_ready = (state_reg == IDLE) & ~bus.clr;
  assign bus.busy      = (state_reg == SHIFT);
  assign bus.done      = done_reg;
  assign bus.data_out  = chain_reg;

endmodule

// File: tb/tb_shift_chain_seq.sv
// Self-checking bench for shift_chain_seq (WIDTH=8, CNT_W=4): directed vector
// table, hand-written corner sequences, and random commands against an
// arithmetic reference model.
module tb_shift_chain_seq;
  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  shift_chain_if #(.WIDTH(W), .CNT_W(C)) bus ();

  shift_chain_seq #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         do_load;
    logic [7:0] load_val;
    bit         dir;
    logic [1:0] mode;
    bit         fill;
    int         count;
    logic [7:0] expected;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result from the operation's meaning, not step by step
  function automatic logic [7:0] model(input logic [7:0] v, input bit dir,
                                       input logic [1:0] mode, input bit fill, input int n);
    logic [31:0] x;
    logic [31:0] r;
    logic [31:0] fm;
    int k;
    int m;
    x = {24'd0, v};
    r = 0;
    m = (n < W) ? n : W;
    case (mode)
      2'b00: r = dir ? (x >> n) : (x << n);
      2'b01: begin
        fm = fill ? ((32'd1 << m) - 1) : 32'd0;
        r  = dir ? ((x >> n) | (fm << (W - m))) : ((x << n) | fm);
      end
      2'b10: begin
        k = n % W;
        r = dir ? ((x >> k) | (x << (W - k))) : ((x << k) | (x >> (W - k)));
      end
      default: begin
        if (dir) r = 32'($signed({{24{v[7]}}, v}) >>> n);
        else     r = x << n;
      end
    endcase
    return r[7:0];
  endfunction

  // Optional load, then one command; checks busy length, final value, handshake.
  // While busy, command inputs and load are scrambled and must have no effect.
  task automatic run_cmd(input string name, input bit do_load, input logic [7:0] lv,
                         input bit dir, input logic [1:0] mode, input bit fill,
                         input int n, input logic [7:0] exp);
    int busy_cycles;
    bit seen;
    if (do_load) begin
      bus.load = 1'b1; bus.load_data = lv;
      tick();
      bus.load = 1'b0;
    end
    check({name, ".ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_dir = dir; bus.cmd_mode = mode;
    bus.cmd_fill = fill; bus.cmd_count = C'(n);
    tick();
    bus.cmd_valid = 1'b0;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      bus.cmd_valid = 1'($urandom); bus.cmd_dir = 1'($urandom);
      bus.cmd_mode = 2'($urandom); bus.cmd_fill = 1'($urandom);
      bus.cmd_count = C'($urandom); bus.load = 1'($urandom);
      bus.load_data = 8'($urandom);
      tick();
    end
    bus.cmd_valid = 1'b0; bus.load = 1'b0;
    check({name, ".done_seen"}, 32'(seen), 32'd1);
    check({name, ".data"}, 32'(bus.data_out), 32'(exp));
    check({name, ".busy_cycles"}, 32'(busy_cycles), 32'(n));
    check({name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    check({name, ".ready_at_done"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    check({name, ".done_pulse"}, 32'(bus.done), 32'd0);
    $display("txn %s load=%0b lv=%02h dir=%0b mode=%0d fill=%0b n=%0d -> data=%02h exp=%02h",
             name, do_load, lv, dir, mode, fill, n, bus.data_out, exp);
  endtask

  vec_t vecs[8];

  initial begin
    int abort_done;
    logic [7:0] rv;
    logic [7:0] held;
    bit rd;
    logic [1:0] rm;
    bit rf;
    int rn;

    vecs[0] = '{"t1_zero_left",    1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 3,  8'h28};
    vecs[1] = '{"t2_arith_right",  1'b1, 8'h81, 1'b1, 2'b11, 1'b0, 2,  8'hE0};
    vecs[2] = '{"t2_rot_right9",   1'b1, 8'h81, 1'b1, 2'b10, 1'b0, 9,  8'hC0};
    vecs[3] = '{"t3_fill_left8",   1'b1, 8'h00, 1'b0, 2'b01, 1'b1, 8,  8'hFF};
    vecs[4] = '{"t3_count0_held",  1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 0,  8'hFF};
    vecs[5] = '{"fill_right15",    1'b1, 8'h3C, 1'b1, 2'b01, 1'b1, 15, 8'hFF};
    vecs[6] = '{"rot_left_full",   1'b1, 8'h96, 1'b0, 2'b10, 1'b0, 8,  8'h96};
    vecs[7] = '{"zero_right15",    1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 15, 8'h00};

    bus.clr = 1'b0; bus.load = 1'b0; bus.load_data = '0; bus.cmd_valid = 1'b0;
    bus.cmd_dir = 1'b0; bus.cmd_mode = 2'b00; bus.cmd_fill = 1'b0; bus.cmd_count = '0;

    // Reset state
    #12;
    check("reset.data", 32'(bus.data_out), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.ready", 32'(bus.cmd_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].name, vecs[i].do_load, vecs[i].load_val, vecs[i].dir,
              vecs[i].mode, vecs[i].fill, vecs[i].count, vecs[i].expected);

    // clr after two steps aborts the command with no done
    bus.load = 1'b1; bus.load_data = 8'h5A; tick(); bus.load = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_mode = 2'b10; bus.cmd_count = C'(5);
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick();
    check("clr.two_steps", 32'(bus.data_out), 32'h69);
    bus.clr = 1'b1;
    #1;
    check("clr.ready_low", 32'(bus.cmd_ready), 32'd0);
    tick();
    bus.clr = 1'b0;
    check("clr.data", 32'(bus.data_out), 32'd0);
    check("clr.busy", 32'(bus.busy), 32'd0);
    abort_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) abort_done++;
      tick();
    end
    check("clr.no_done", 32'(abort_done), 32'd0);
    $display("txn clr_abort data=%02h", bus.data_out);

    // load and cmd_valid together: load wins, command taken next cycle;
    // a load during busy is ignored
    bus.load = 1'b1; bus.load_data = 8'h0F;
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_mode = 2'b00; bus.cmd_count = C'(2);
    #1;
    check("ldcmd.ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.load = 1'b0;
    check("ldcmd.loaded", 32'(bus.data_out), 32'h0F);
    check("ldcmd.not_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    check("ldcmd.accepted", 32'(bus.busy), 32'd1);
    bus.load = 1'b1; bus.load_data = 8'hFF;
    tick();
    bus.load = 1'b0;
    check("ldcmd.load_ignored", 32'(bus.data_out), 32'h1E);
    tick();
    check("ldcmd.final", 32'(bus.data_out), 32'h3C);
    check("ldcmd.done", 32'(bus.done), 32'd1);
    $display("txn load_vs_cmd data=%02h", bus.data_out);
    tick();

    // Asynchronous reset mid-command takes effect without a clock edge
    bus.load = 1'b1; bus.load_data = 8'hC3; tick(); bus.load = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_mode = 2'b11; bus.cmd_count = C'(10);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.data", 32'(bus.data_out), 32'd0);
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.done", 32'(bus.done), 32'd0);
    check("arst.ready", 32'(bus.cmd_ready), 32'd1);
    $display("txn async_reset data=%02h busy=%0b", bus.data_out, bus.busy);
    #3;
    rst_n = 1'b1;
    tick();

    // Random commands against the reference model
    held = 8'h00;
    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom);
      rd = 1'($urandom);
      rm = 2'($urandom);
      rf = 1'($urandom);
      rn = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) held = rv;
      else rv = held;
      run_cmd($sformatf("rnd%0d", i), 1'b1, rv, rd, rm, rf, rn, model(rv, rd, rm, rf, rn));
      held = bus.data_out;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
